// File: rtl/bram_std_fifo.sv
// bram_std_fifo
// Single-clock FIFO with standard (registered, non-fall-through) read data.
// Storage is a simple dual-port array written and read on the rising edge,
// so it maps onto block RAM with its output register.
// Optional feature: define BRAM_STD_FIFO_COUNT_EN to add the 'level' output
// (current occupancy, 0..2**ADDR_WIDTH, same timing as full/empty).
module bram_std_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dest_data,
  output logic                  full,
  output logic                  empty
`ifdef BRAM_STD_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  // Occupancy value that means "every slot holds a word".
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_acc;
  logic                  wr_acc;

  // Flags come straight from the occupancy counter, so they change the
  // cycle after the operation that moved the count.
  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);

`ifdef BRAM_STD_FIFO_COUNT_EN
  assign level = count;
`endif

  // A read frees a slot in the same edge, so a write into a full FIFO is
  // accepted only when paired with an accepted read. A read while empty is
  // never accepted, which also keeps a new word from falling through.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Storage write port.
  // NOTE: the array has no reset on purpose; a reset branch here would stop
  // the tools from mapping it onto block RAM. Stale words are unreachable
  // anyway because reset clears the pointers and the count.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      // NOTE: non-blocking assignments in every clocked block so all state
      // updates use pre-edge values regardless of statement order.
      mem[wr_ptr] <= src_data;
    end
  end

  // Pointer advance; both wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy tracking; a simultaneous read and write leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Registered read port; holds its last value when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_data <= '0;
    end else if (rd_acc) begin
      dest_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_bram_std_fifo.sv
// tb_bram_std_fifo
// Self-checking bench for bram_std_fifo (DATA_WIDTH=8, ADDR_WIDTH=3):
// a vector table, hand-written corner-case sequences, then random traffic
// compared against a queue-based reference model.
module tb_bram_std_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] src_data;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] dest_data;
  logic          full;
  logic          empty;
`ifdef BRAM_STD_FIFO_COUNT_EN
  logic [AW:0]   level;
`endif

  int tests  = 0;
  int errors = 0;

  // Reference model: a queue of stored words and the expected read register.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dest = '0;

  bram_std_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_data (src_data),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .dest_data(dest_data),
    .full     (full),
    .empty    (empty)
`ifdef BRAM_STD_FIFO_COUNT_EN
    ,
    .level    (level)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_dest;
    logic          exp_full;
    logic          exp_empty;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check3(input string name, input logic [DW-1:0] d, input logic f, input logic e);
    check({name, " dest"},  32'(dest_data), 32'(d));
    check({name, " full"},  32'(full),      32'(f));
    check({name, " empty"}, 32'(empty),     32'(e));
  endtask

  // Drive one cycle, advance the model on the same edge, sample 1 ns later.
  task automatic cyc(input logic r, input logic w, input logic rd_i, input logic [DW-1:0] d);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd_i; src_data = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_dest = '0;
    end else begin
      rd_ok = rd_i && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) m_dest = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
  endtask

  task automatic check_model(input int n);
    check($sformatf("rnd%0d dest", n),  32'(dest_data), 32'(m_dest));
    check($sformatf("rnd%0d full", n),  32'(full),      32'(q.size() == DEPTH));
    check($sformatf("rnd%0d empty", n), 32'(empty),     32'(q.size() == 0));
`ifdef BRAM_STD_FIFO_COUNT_EN
    check($sformatf("rnd%0d level", n), 32'(level),     32'(q.size()));
`endif
  endtask

  function automatic vec_t mk(logic r, logic w, logic rd_i, logic [DW-1:0] d,
                              logic [DW-1:0] ed, logic ef, logic ee);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd_i; v.data = d;
    v.exp_dest = ed; v.exp_full = ef; v.exp_empty = ee;
    return v;
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; src_data = '0;

    // Reset for two cycles, fill with A1..A8, try to overfill, drain, read on empty.
    vecs[0] = mk(1, 0, 0, 8'h00, 8'h00, 0, 1);
    vecs[1] = mk(1, 0, 0, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++)
      vecs[2+i] = mk(0, 1, 0, 8'(8'hA1 + i), 8'h00, (i == 7), 0);
    vecs[10] = mk(0, 1, 0, 8'hFF, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++)
      vecs[11+i] = mk(0, 0, 1, 8'h00, 8'(8'hA1 + i), 0, (i == 7));
    vecs[19] = mk(0, 0, 1, 8'h00, 8'hA8, 0, 1);

    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].data);
      check3($sformatf("vec%0d", i), vecs[i].exp_dest, vecs[i].exp_full, vecs[i].exp_empty);
    end

    // Count held at 3 while reading and writing together.
    cyc(0, 1, 0, 8'h11);
    cyc(0, 1, 0, 8'h22);
    cyc(0, 1, 0, 8'h33);
    cyc(0, 1, 1, 8'h44); check3("rw3 a", 8'h11, 0, 0);
    cyc(0, 1, 1, 8'h44); check3("rw3 b", 8'h22, 0, 0);
    cyc(0, 1, 1, 8'h44); check3("rw3 c", 8'h33, 0, 0);
    cyc(0, 0, 1, 8'h00); check3("rw3 d", 8'h44, 0, 0);
    cyc(0, 0, 1, 8'h00); check3("rw3 e", 8'h44, 0, 0);
    cyc(0, 0, 1, 8'h00); check3("rw3 f", 8'h44, 0, 1);
    cyc(0, 0, 1, 8'h00); check3("rd empty hold", 8'h44, 0, 1);

    // Read+write while full returns the oldest word; the new word comes out last.
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'(8'hB0 + i));
    check3("fill b", 8'h44, 1, 0);
    cyc(0, 1, 1, 8'h55); check3("full rw", 8'hB0, 1, 0);
    for (int i = 1; i < 8; i++) begin
      cyc(0, 0, 1, 8'h00);
      check3($sformatf("drain b%0d", i), 8'(8'hB0 + i), 0, 0);
    end
    cyc(0, 0, 1, 8'h00); check3("drain 55", 8'h55, 0, 1);

    // Read+write on empty: read ignored, no fall-through.
    cyc(0, 1, 1, 8'h66); check3("empty rw", 8'h55, 0, 0);
    cyc(0, 0, 1, 8'h00); check3("empty rw rd", 8'h66, 0, 1);

    // Reset mid-operation discards stored words; traffic during reset ignored.
    cyc(0, 1, 0, 8'hC1);
    cyc(0, 1, 0, 8'hC2);
    cyc(0, 1, 0, 8'hC3);
    cyc(1, 0, 0, 8'h00); check3("mid rst", 8'h00, 0, 1);
    cyc(1, 1, 1, 8'h99); check3("rst ignores", 8'h00, 0, 1);
    cyc(0, 1, 0, 8'h77); check3("post rst wr", 8'h00, 0, 0);
    cyc(0, 0, 1, 8'h00); check3("post rst rd", 8'h77, 0, 1);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 99) < 55),
          ($urandom_range(0, 99) < 50),
          8'($urandom));
      check_model(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
